if_id_buf: RTL and testbench
============================

Name: if_id_buf

Overview:
- Elastic fetch-to-decode buffer that sits between the instruction fetch logic and the `id` decode stage.
- Holds up to DEPTH fetched instruction/address pairs in a circular FIFO with a valid/ready handshake on both sides.
- Lets fetch run ahead while decode is stalled.
- Discards every buffered wrong-path instruction in one cycle when a flush arrives (jump/branch taken in ex).

Parameters:
- DEPTH, 2: number of entries; power of two, minimum 2.
- NOP_INST, 32'h00000013: instruction presented to id when the buffer has nothing valid (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- inst_i  in  32  instruction word from fetch.
- inst_addr_i  in  32  PC of inst_i.
- inst_valid_i  in  1  fetch presents a valid instruction.
- inst_ready_o  out  1  buffer accepts; a push occurs when inst_valid_i && inst_ready_o && !flush_i.
- inst_o  out  32  head instruction to id.
- inst_addr_o  out  32  head PC to id.
- inst_valid_o  out  1  head entry valid.
- id_ready_i  in  1  id consumes; a pop occurs when inst_valid_o && id_ready_i.
- flush_i  in  1  jump/branch flush from ex.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All storage entries = {NOP_INST, 32'h0}.
  - Outputs: inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, inst_ready_o=1, count_o=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count holds 0..DEPTH.
- inst_ready_o = (count != DEPTH). It depends on registered state only; there is no combinational path from id_ready_i or flush_i.
- Output when count > 0: inst_o and inst_addr_o come from mem[rd_ptr], and inst_valid_o = !flush_i.
- Output when count == 0: inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0 (bypass case excepted, see Optional Feature).
- Latency: an instruction pushed at edge N is visible at the head after edge N when the buffer was empty (1 cycle, no bypass).
- Push only: mem[wr_ptr] written, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle:
  - Both pointers advance; count is unchanged.
  - This is legal at any count < DEPTH.
  - At count==DEPTH no push occurs (ready low), so a pop alone proceeds.
  - At count==0 no pop occurs (valid low), so a push alone proceeds.
- Flush has priority over push and pop:
  - At the next edge wr_ptr=rd_ptr=0 and count=0.
  - Input presented in the flush cycle is dropped.
  - inst_valid_o is forced 0 during the flush cycle, so id never consumes a wrong-path instruction.
  - Storage contents need not be cleared.
- Flush while count==0: no effect beyond holding count at 0.
- id_ready_i held low with count==DEPTH: ready stays low; head and contents are held stable indefinitely.
- Order is strict FIFO. No entry is duplicated or dropped except by flush.

Optional Feature:
- Macro IF_ID_BUF_BYPASS_EN.
- Defined:
  - When count==0 and !flush_i, the outputs follow the input combinationally: inst_valid_o=inst_valid_i, inst_o=inst_i, inst_addr_o=inst_addr_i.
  - If id_ready_i is also high, the instruction is consumed directly and not written. Latency is 0 cycles.
  - If id_ready_i is low, it is written normally.
- Undefined: empty-buffer output is NOP/invalid as above, with a fixed 1-cycle latency. No combinational path from the inst_* inputs to the outputs.

Decomposition:
- Shared defines header (existing core defines):
  - `InstBus, `InstAddrBus, `ZeroWord.
  - New `INST_NOP = 32'h00000013, which NOP_INST defaults to.
- Natural sub-module: pipe_fifo, a generic parameterised synchronous FIFO with WIDTH/DEPTH, push/pop/clear, and count.
  - if_id_buf instantiates it with WIDTH=64 and adds the flush gating, the NOP substitution, and the bypass.

Test Plan:
- Reset with rst pulsed asynchronously mid-cycle -> inst_valid_o=0, inst_o=32'h00000013, count_o=0, inst_ready_o=1 immediately.
- Push PC 0x00/0x04/0x08 with id_ready_i=0, DEPTH=2:
  - After 2 edges count_o=2 and inst_ready_o=0; 0x08 is held off.
  - Raise id_ready_i -> id receives 0x00, 0x04, 0x08 in order with no gaps.
- Continuous push and pop, id_ready_i=1, 16 instructions -> count_o stays 1 and throughput is 1 per cycle; also checks pointer wrap past index 1.
- Buffer full (0x10, 0x14), flush_i=1 with inst_valid_i=1 (0x18) in the same cycle:
  - inst_valid_o=0 in that cycle; next cycle count_o=0 and 0x18 is absent.
  - Then push 0x80 -> 0x80 is the next head.
- Pop and push at count==1 -> count_o remains 1 and the head advances to the new entry one cycle later.
- With IF_ID_BUF_BYPASS_EN, empty buffer, inst 0x00500093 @0x20, id_ready_i=1 -> inst_o=0x00500093 in the same cycle and count_o stays 0.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
// Shared fetch/decode defines and the buffer entry type used by if_id_buf.
// The core's bus-width macros live here so every file compiled after this one sees them.
`ifndef IF_ID_BUF_DEFINES
`define IF_ID_BUF_DEFINES
`define InstBus     31:0
`define InstAddrBus 31:0
`define ZeroWord    32'h00000000
`define INST_NOP    32'h00000013
`endif

package if_id_buf_pkg;

    typedef struct packed {
        logic [`InstBus]     inst;
        logic [`InstAddrBus] addr;
    } fetch_ent_t;

    localparam int ENT_W = $bits(fetch_ent_t);

    function automatic fetch_ent_t make_entry(input logic [`InstBus] inst,
                                              input logic [`InstAddrBus] addr);
        fetch_ent_t e;
        e.inst = inst;
        e.addr = addr;
        return e;
    endfunction

endpackage

// File: rtl/if_id_buf_pipe_fifo.sv
// Generic circular FIFO: registered head (1-cycle write-to-head), push ignored when full,
// pop ignored when empty, clear empties it in one cycle and drops any same-cycle push.
module pipe_fifo #(
    parameter int                WIDTH     = 64,
    parameter int                DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Clear only rewinds the pointers; stale storage is unreachable afterwards.
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_id_buf.sv
// Elastic fetch-to-decode buffer; 1-cycle latency (0 with IF_ID_BUF_BYPASS_EN when empty).
// Ready drops only when full (registered); flush empties it in one cycle and masks the head.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [`InstBus]   NOP_INST = `INST_NOP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [`InstBus]          inst_i,
    input  logic [`InstAddrBus]      inst_addr_i,
    input  logic                     inst_valid_i,
    output logic                     inst_ready_o,
    output logic [`InstBus]          inst_o,
    output logic [`InstAddrBus]      inst_addr_o,
    output logic                     inst_valid_o,
    input  logic                     id_ready_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam fetch_ent_t RESET_ENT = '{inst: NOP_INST, addr: `ZeroWord};

    logic [ENT_W-1:0] head_dat;
    fetch_ent_t       head_ent;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             bypass_take;

    assign head_ent     = fetch_ent_t'(head_dat);
    assign inst_ready_o = !fifo_full;

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = NOP_INST;
        inst_addr_o  = `ZeroWord;
        bypass_take  = 1'b0;
        // A flush masks the head so id can never consume a wrong-path instruction.
        if (!fifo_empty) begin
            inst_valid_o = !flush_i;
            inst_o       = head_ent.inst;
            inst_addr_o  = head_ent.addr;
        end
`ifdef IF_ID_BUF_BYPASS_EN
        else if (!flush_i) begin
            inst_valid_o = inst_valid_i;
            inst_o       = inst_i;
            inst_addr_o  = inst_addr_i;
            bypass_take  = inst_valid_i && id_ready_i;
        end
`endif
    end

    assign fifo_push = inst_valid_i && inst_ready_o && !flush_i && !bypass_take;
    assign fifo_pop  = inst_valid_o && id_ready_i && !fifo_empty;

    pipe_fifo #(
        .WIDTH     (ENT_W),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_ENT)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (make_entry(inst_i, inst_addr_i)),
        .pop_i      (fifo_pop),
        .clear_i    (flush_i),
        .head_dat_o (head_dat),
        .count_o    (count_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_if_id_buf.sv
// Self-checking bench for if_id_buf: directed vector table, hand sequences, and a random
// run against a queue-based reference model.
module tb_if_id_buf;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_valid_i = 1'b0;
    logic        inst_ready_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        id_ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  count_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    if_id_buf #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .inst_valid_i (inst_valid_i),
        .inst_ready_o (inst_ready_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o),
        .id_ready_i   (id_ready_i),
        .flush_i      (flush_i),
        .count_o      (count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'hC0DE0000 | a;
    endfunction

    typedef struct {
        logic        vi;
        logic [31:0] addr;
        logic        idr;
        logic        fl;
        logic        e_vld;
        logic [31:0] e_addr;
        logic [1:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t vt [15];

    task automatic drive(input logic vi, input logic [31:0] a, input logic [31:0] ins,
                         input logic idr, input logic fl);
        inst_valid_i = vi;
        inst_addr_i  = a;
        inst_i       = ins;
        id_ready_i   = idr;
        flush_i      = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered list of pending {inst, addr} entries.
    logic [63:0] q [$];

    initial begin
        logic        e_vld;
        logic [31:0] e_inst, e_addr;
        logic        pop_m, push_m, byp;

        // Addresses with an e_vld of 0 and count 0 expect NOP/0 at the head.
        vt[0]  = '{1, 32'h00, 0, 0, 0, 32'h00, 2'd0, 1};
        vt[1]  = '{1, 32'h04, 0, 0, 1, 32'h00, 2'd1, 1};
        vt[2]  = '{1, 32'h08, 0, 0, 1, 32'h00, 2'd2, 0};
        vt[3]  = '{1, 32'h08, 1, 0, 1, 32'h00, 2'd2, 0};
        vt[4]  = '{1, 32'h08, 1, 0, 1, 32'h04, 2'd1, 1};
        vt[5]  = '{0, 32'h00, 1, 0, 1, 32'h08, 2'd1, 1};
        vt[6]  = '{0, 32'h00, 1, 0, 0, 32'h00, 2'd0, 1};
        vt[7]  = '{1, 32'h10, 0, 0, 0, 32'h00, 2'd0, 1};
        vt[8]  = '{1, 32'h14, 0, 0, 1, 32'h10, 2'd1, 1};
        vt[9]  = '{1, 32'h18, 1, 1, 0, 32'h10, 2'd2, 0};
        vt[10] = '{1, 32'h80, 0, 0, 0, 32'h00, 2'd0, 1};
        vt[11] = '{0, 32'h00, 1, 0, 1, 32'h80, 2'd1, 1};
        vt[12] = '{0, 32'h00, 0, 0, 0, 32'h00, 2'd0, 1};
        vt[13] = '{1, 32'h90, 0, 1, 0, 32'h00, 2'd0, 1};
        vt[14] = '{0, 32'h00, 0, 0, 0, 32'h00, 2'd0, 1};

        // Reset state
        #12;
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst",  inst_o, NOP);
        chk("rst_addr",  inst_addr_o, 32'h0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(inst_ready_o), 32'd1);
        rst = 1'b0;
        next_cycle();

        // Directed vector table: drive, sample at negedge, then advance
        for (int i = 0; i < 15; i++) begin
            logic        x_vld;
            logic [31:0] x_inst, x_addr;
            drive(vt[i].vi, vt[i].addr, inst_of(vt[i].addr), vt[i].idr, vt[i].fl);
            x_vld  = vt[i].e_vld;
            x_addr = vt[i].e_addr;
            x_inst = (vt[i].e_cnt == 0) ? NOP : inst_of(vt[i].e_addr);
`ifdef IF_ID_BUF_BYPASS_EN
            if (vt[i].e_cnt == 0 && !vt[i].fl) begin
                x_vld  = vt[i].vi;
                x_addr = vt[i].vi ? vt[i].addr : 32'h0;
                x_inst = vt[i].vi ? inst_of(vt[i].addr) : 32'h0;
            end
`endif
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(inst_valid_o), 32'(x_vld));
            if (!(vt[i].e_cnt == 0 && x_vld == 0 && vt[i].vi && !vt[i].fl)) begin
                chk($sformatf("vec%0d_inst", i), inst_o, x_inst);
                chk($sformatf("vec%0d_addr", i), inst_addr_o, x_addr);
            end
            chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_ready", i), 32'(inst_ready_o), 32'(vt[i].e_rdy));
            next_cycle();
        end

        // Asynchronous reset asserted mid-cycle with the buffer occupied
        drive(1, 32'h200, inst_of(32'h200), 0, 0);
        next_cycle();
        next_cycle();
        drive(0, 0, 0, 0, 0);
        chk("pre_arst_count", 32'(count_o), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(inst_valid_o), 32'd0);
        chk("arst_inst",  inst_o, NOP);
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_ready", 32'(inst_ready_o), 32'd1);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Streaming: one push and one pop per cycle across pointer wrap
        for (int k = 0; k <= 16; k++) begin
            logic [31:0] a;
            a = 32'h100 + 32'(4 * k);
            if (k < 16) drive(1, a, inst_of(a), 1, 0);
            else        drive(0, 0, 0, 1, 0);
            @(negedge clk);
`ifdef IF_ID_BUF_BYPASS_EN
            if (k < 16) begin
                chk($sformatf("stream%0d_addr", k), inst_addr_o, a);
                chk($sformatf("stream%0d_count", k), 32'(count_o), 32'd0);
            end
`else
            if (k >= 1) begin
                chk($sformatf("stream%0d_valid", k), 32'(inst_valid_o), 32'd1);
                chk($sformatf("stream%0d_addr", k), inst_addr_o, a - 32'd4);
                chk($sformatf("stream%0d_count", k), 32'(count_o), 32'd1);
            end
`endif
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stream_drained", 32'(count_o), 32'd0);
        next_cycle();

`ifdef IF_ID_BUF_BYPASS_EN
        drive(1, 32'h20, 32'h00500093, 1, 0);
        @(negedge clk);
        chk("byp_valid", 32'(inst_valid_o), 32'd1);
        chk("byp_inst",  inst_o, 32'h00500093);
        chk("byp_addr",  inst_addr_o, 32'h20);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("byp_count", 32'(count_o), 32'd0);
        next_cycle();
`endif

        // Random traffic against the reference model
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] ra;
            ra = $urandom() & 32'hFFFF_FFFC;
            drive($urandom_range(0, 3) != 0, ra, $urandom(),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);

            e_vld  = 1'b0;
            e_inst = NOP;
            e_addr = 32'h0;
            byp    = 1'b0;
            if (q.size() > 0) begin
                e_vld  = !flush_i;
                e_inst = q[0][63:32];
                e_addr = q[0][31:0];
            end
`ifdef IF_ID_BUF_BYPASS_EN
            else if (!flush_i) begin
                e_vld  = inst_valid_i;
                e_inst = inst_i;
                e_addr = inst_addr_i;
                byp    = inst_valid_i && id_ready_i;
            end
`endif
            @(negedge clk);
            chk("rnd_valid", 32'(inst_valid_o), 32'(e_vld));
            chk("rnd_inst",  inst_o, e_inst);
            chk("rnd_addr",  inst_addr_o, e_addr);
            chk("rnd_count", 32'(count_o), 32'(q.size()));
            chk("rnd_ready", 32'(inst_ready_o), 32'(q.size() != DEPTH));

            if (flush_i) begin
                q.delete();
            end else begin
                pop_m  = e_vld && id_ready_i && q.size() > 0;
                push_m = inst_valid_i && (q.size() != DEPTH) && !byp;
                if (pop_m)  void'(q.pop_front());
                if (push_m) q.push_back({inst_i, inst_addr_i});
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
